apb_slave: RTL and testbench
============================

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, byte-address width.
REQ-003 Parameter MEM_DEPTH, default 64, number of DATA_WIDTH-bit words in the register array.
REQ-004 Parameter WAIT_STATES, default 0, number of pready-low cycles inserted per access phase; range 0..15.
REQ-005 Parameter SECURE_WORDS, default 4, words 0..SECURE_WORDS-1 forming the secure region.
REQ-006 Derived BYTES_PER_WORD = DATA_WIDTH/8; derived OFFS = log2(BYTES_PER_WORD).
REQ-007 pclk  in  1  sole clock; all state updates on its rising edge.
REQ-008 preset  in  1  reset; synchronous, active-high.
REQ-009 psel  in  1  this slave's select bit from the master's psel vector.
REQ-010 penable  in  1  access-phase indicator.
REQ-011 paddr  in  ADDR_WIDTH  byte address.
REQ-012 pwrite  in  1  1 = write, 0 = read.
REQ-013 pwdata  in  DATA_WIDTH  write data.
REQ-014 pstrb  in  BYTES_PER_WORD  write byte-lane enables.
REQ-015 pprot  in  3  protection; bit 1 = non-secure.
REQ-016 pready  out  1  transfer completion.
REQ-017 prdata  out  DATA_WIDTH  read data; valid only while pready=1 on a read.
REQ-018 pslverr  out  1  transfer error; valid only while pready=1.

Function
REQ-019 States: IDLE and ACCESS.
REQ-020 IDLE: if psel=1 and penable=0 (setup phase), the block captures paddr, pwrite, pwdata, pstrb and pprot, loads the wait counter with WAIT_STATES, and enters ACCESS on the next edge.
REQ-021 IDLE: psel=1 with penable=1 is a protocol violation; the block ignores it, stays in IDLE, and holds pready=0.
REQ-022 ACCESS: pready=0 while the wait counter is non-zero; the counter decrements by 1 on each edge where psel=1 and penable=1.
REQ-023 ACCESS: pready=1, combinationally decoded from state and counter, when the counter is 0; with WAIT_STATES=0, pready is therefore 1 in the first access cycle.
REQ-024 Completion edge (ACCESS, psel=1, penable=1, pready=1): a non-error write updates the enabled byte lanes of the word; state returns to IDLE.
REQ-025 Back-to-back transfers: the master's next setup phase is sampled in IDLE on the cycle after completion; no extra idle cycle is required.
REQ-026 Word index = captured paddr[ADDR_WIDTH-1:OFFS]; each pstrb[i]=1 writes byte lane i; a write with pstrb=0 completes without modifying memory.
REQ-027 Reads ignore pstrb; prdata is the full word at the captured index.
REQ-028 Error conditions, evaluated on captured fields:
  - word index >= MEM_DEPTH;
  - paddr[OFFS-1:0] != 0;
  - pprot[1]=1 and word index < SECURE_WORDS.
REQ-029 On error: pslverr=1 with pready=1, writes are suppressed, and prdata=0.
REQ-030 pslverr=0 and prdata=0 whenever pready=0.
REQ-031 Abort: psel=0 while in ACCESS returns the block to IDLE on the next edge, with no memory update and pready=0.
REQ-032 Captured fields are used for the whole access; input changes after setup have no effect.

Reset
REQ-033 While preset=1 at a clock edge: state becomes IDLE, the wait counter becomes 0, and all memory words become 0.
REQ-034 Outputs after reset: pready=0, pslverr=0, prdata=0.
REQ-035 Reset asserted mid-access aborts the transfer; no write is performed on that edge.

Structure
REQ-036 Shared package apb_pkg holds:
  - state enum apb_slv_state_e {IDLE, ACCESS};
  - pprot bit-index constants;
  - default width constants.
REQ-037 One sub-module, apb_slave_mem, implements the byte-enabled MEM_DEPTH x DATA_WIDTH register array with synchronous write and combinational read.
REQ-038 The FSM, wait counter and error decode reside in apb_slave.

Verification
REQ-039 Write then read, WAIT_STATES=0: write 0xDEADBEEF to 0x010 with pstrb=0xF and pprot=0, then read 0x010 -> each pready=1 in the first access cycle; prdata=0xDEADBEEF; pslverr=0.
REQ-040 Strobe: word 0x020=0x11223344, then write 0xAABBCCDD with pstrb=0x5 -> readback 0x11BB33DD.
REQ-041 WAIT_STATES=3 -> pready low for exactly 3 access cycles and high on the 4th; the master's penable stays 1 throughout.
REQ-042 Errors:
  - read at 0x100 (index 64) -> pslverr=1, prdata=0;
  - write at 0x013 (misaligned) -> pslverr=1, memory unchanged;
  - pprot=3'b010 write to 0x004 -> pslverr=1, word 1 unchanged.
REQ-043 Abort/reset:
  - psel dropped mid-wait -> IDLE, no write;
  - preset=1 during ACCESS -> pready=0 next cycle, and all words read back 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, pprot bit positions
// and default bus/array dimensions.
package apb_pkg;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  localparam int APB_DATA_W    = 32;
  localparam int APB_ADDR_W    = 10;
  localparam int APB_MEM_DEPTH = 64;

endpackage

// File: rtl/apb_slave_mem.sv
// Byte-enabled register array: synchronous clear and write, combinational read.
module apb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  localparam int BPW = DATA_WIDTH / 8,
  localparam int AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BPW-1:0]        wstrb_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < BPW; b++)
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Guard keeps non-power-of-two depths from reading past the array.
  assign rdata_o = (32'(raddr_i) < 32'(MEM_DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/apb_slave.sv
// APB completer with optional wait states, address/alignment/secure-region
// error decode and a byte-enabled register array behind it.
module apb_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH   = APB_DATA_W,
  parameter int ADDR_WIDTH   = APB_ADDR_W,
  parameter int MEM_DEPTH    = APB_MEM_DEPTH,
  parameter int WAIT_STATES  = 0,
  parameter int SECURE_WORDS = 4,
  localparam int BPW  = DATA_WIDTH / 8,
  localparam int OFFS = (BPW > 1) ? $clog2(BPW) : 0,
  localparam int AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [BPW-1:0]        pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  apb_slv_state_e        state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BPW-1:0]        strb_q;
  logic                  nsec_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  err, complete, mem_we;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_prot;

  assign unused_prot = ^{pprot[PPROT_PRIV], pprot[PPROT_INSTR]};

  assign idx = addr_q >> OFFS;
  assign err = (32'(idx) >= 32'(MEM_DEPTH))
            || ((addr_q & ADDR_WIDTH'(BPW - 1)) != '0)
            || (nsec_q && (32'(idx) < 32'(SECURE_WORDS)));

  assign pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete = pready && psel && penable;
  assign mem_we   = complete && write_q && !err && !preset;
  assign pslverr  = pready && err;
  assign prdata   = (pready && !write_q && !err) ? rdata : '0;

  // Setup is only accepted from IDLE with penable low; an access phase with
  // psel dropped is an abort and returns to IDLE without touching memory.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      nsec_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (psel && !penable) begin
          addr_q  <= paddr;
          write_q <= pwrite;
          wdata_q <= pwdata;
          strb_q  <= pstrb;
          nsec_q  <= pprot[PPROT_NONSEC];
          cnt_q   <= 4'(WAIT_STATES);
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (!psel) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (penable) begin
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            else               state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we),
    .waddr_i (idx[AW-1:0]),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .raddr_i (idx[AW-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: zero-wait instance (a) and three-wait instance (b)
// sharing one APB bus, each with its own psel.
module tb_apb_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel_a, psel_b, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic [31:0] prdata_a, prdata_b;
  logic        sel_b;
  logic        rdy, slverr;
  logic [31:0] rdat;

  int n_chk = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_slave #(.WAIT_STATES(0)) u_dut_a (
    .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a)
  );

  apb_slave #(.WAIT_STATES(3)) u_dut_b (
    .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b)
  );

  assign rdy    = sel_b ? pready_b  : pready_a;
  assign slverr = sel_b ? pslverr_b : pslverr_a;
  assign rdat   = sel_b ? prdata_b  : prdata_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the completion edge so a
  // following call issues its setup phase back-to-back.
  task automatic xfer(input bit b, input bit wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output logic er, output int waits);
    bit done  = 0;
    bit quiet = 1;
    sel_b = b;
    psel_a = !b; psel_b = b; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    rd = '0; er = 1'b0; waits = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    // Scramble bus fields: the slave must use what it captured at setup.
    paddr = 10'h3FF; pwdata = ~d; pstrb = ~s; pwrite = !wr; pprot = ~p;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (rdy) begin
        rd = rdat; er = slverr; done = 1;
      end else begin
        waits++;
        if (slverr || rdat != 0) quiet = 0;
      end
      @(posedge pclk); #1;
    end
    chk("no_timeout", 32'(done), 32'd1);
    chk("quiet_while_wait", 32'(quiet), 32'd1);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    preset = 1'b1; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; sel_b = 0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_pready_a", 32'(pready_a), 32'd0);
    chk("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    chk("rst_prdata_a", prdata_a, 32'd0);
    chk("rst_pready_b", 32'(pready_b), 32'd0);
    @(posedge pclk); #1;

    // Zero-wait write then read, back-to-back.
    xfer(0, 1, 10'h010, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w);
    chk("wr_waits", 32'(w), 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("rd_waits", 32'(w), 32'd0);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Byte strobes.
    xfer(0, 1, 10'h020, 32'h11223344, 4'hF, 3'b000, rd, er, w);
    xfer(0, 1, 10'h020, 32'hAABBCCDD, 4'h5, 3'b000, rd, er, w);
    xfer(0, 0, 10'h020, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("strb_data", rd, 32'h11BB33DD);
    xfer(0, 1, 10'h020, 32'hFFFFFFFF, 4'h0, 3'b000, rd, er, w);
    chk("strb0_err", 32'(er), 32'd0);
    xfer(0, 0, 10'h020, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("strb0_data", rd, 32'h11BB33DD);

    // Errors.
    xfer(0, 0, 10'h100, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'd0);
    xfer(0, 1, 10'h013, 32'h0BADF00D, 4'hF, 3'b000, rd, er, w);
    chk("misal_err", 32'(er), 32'd1);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("misal_unchanged", rd, 32'hDEADBEEF);
    xfer(0, 1, 10'h004, 32'h12345678, 4'hF, 3'b000, rd, er, w);
    chk("sec_wr_ok", 32'(er), 32'd0);
    xfer(0, 1, 10'h004, 32'h0, 4'hF, 3'b010, rd, er, w);
    chk("nsec_wr_err", 32'(er), 32'd1);
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 3'b010, rd, er, w);
    chk("nsec_rd_err", 32'(er), 32'd1);
    chk("nsec_rd_data", rd, 32'd0);
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("sec_unchanged", rd, 32'h12345678);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b010, rd, er, w);
    chk("nsec_open_err", 32'(er), 32'd0);
    chk("nsec_open_data", rd, 32'hDEADBEEF);

    // Protocol violation: psel+penable straight from IDLE is ignored.
    sel_b = 0; psel_a = 1; penable = 1; pwrite = 1; paddr = 10'h010;
    pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b000;
    @(negedge pclk); chk("viol_pready0", 32'(pready_a), 32'd0);
    @(posedge pclk); #1;
    @(negedge pclk); chk("viol_pready1", 32'(pready_a), 32'd0);
    @(posedge pclk); #1;
    psel_a = 0; penable = 0;
    @(posedge pclk); #1;
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("viol_no_write", rd, 32'hDEADBEEF);

    // Wait states on instance b.
    xfer(1, 1, 10'h008, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, w);
    chk("ws_wr_waits", 32'(w), 32'd3);
    xfer(1, 0, 10'h008, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("ws_rd_waits", 32'(w), 32'd3);
    chk("ws_rd_data", rd, 32'hCAFEF00D);

    // Abort mid-wait on b.
    xfer(1, 1, 10'h018, 32'h00000055, 4'hF, 3'b000, rd, er, w);
    sel_b = 1; psel_b = 1; penable = 0; pwrite = 1; paddr = 10'h018;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1;
    @(negedge pclk); chk("abort_wait", 32'(pready_b), 32'd0);
    @(posedge pclk); #1 psel_b = 0; penable = 0;
    @(negedge pclk); chk("abort_idle", 32'(pready_b), 32'd0);
    @(posedge pclk); #1;
    xfer(1, 0, 10'h018, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("abort_no_write", rd, 32'h00000055);

    // Reset during an access phase.
    sel_b = 1; psel_b = 1; penable = 0; pwrite = 1; paddr = 10'h008;
    pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1; preset = 1;
    @(posedge pclk); #1 preset = 0; psel_b = 0; penable = 0;
    @(negedge pclk); chk("rst_mid_pready", 32'(pready_b), 32'd0);
    @(posedge pclk); #1;
    xfer(1, 0, 10'h008, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("rst_clr_b8", rd, 32'd0);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("rst_clr_a10", rd, 32'd0);
    xfer(0, 0, 10'h020, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("rst_clr_a20", rd, 32'd0);
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 3'b000, rd, er, w);
    chk("rst_clr_a04", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
